// File: rtl/id_ex_pipeline_register_if.sv
// ID/EX boundary bundle: ID-side control/data words in, registered EX-side copies out.
interface id_ex_pipeline_register_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) ();
    logic            flush;
    logic            hold;
    logic            ID_Valid;
    logic            ID_Load_Instr;
    logic            ID_RF_Enable;
    logic            RAM_Enable;
    logic            RAM_RW;
    logic            RAM_SE;
    logic            JALR_Instr;
    logic            JAL_Instr;
    logic            AUIPC_Instr;
    logic [3:0]      ID_ALU_op;
    logic [2:0]      ID_shift_imm;
    logic [1:0]      RAM_Size;
    logic [9:0]      Comb_OpFunct;
    logic [XLEN-1:0] ID_PC;
    logic [XLEN-1:0] ID_RS1_Data;
    logic [XLEN-1:0] ID_RS2_Data;
    logic [XLEN-1:0] ID_Imm;
    logic [4:0]      ID_Rs1;
    logic [4:0]      ID_Rs2;
    logic [4:0]      ID_Rd;

    logic             EX_Valid;
    logic             EX_Load_Instr;
    logic             EX_RF_Enable;
    logic             EX_RAM_Enable;
    logic             EX_RAM_RW;
    logic             EX_RAM_SE;
    logic             EX_JALR_Instr;
    logic             EX_JAL_Instr;
    logic             EX_AUIPC_Instr;
    logic [3:0]       EX_ALU_op;
    logic [2:0]       EX_shift_imm;
    logic [1:0]       EX_RAM_Size;
    logic [9:0]       EX_Comb_OpFunct;
    logic [XLEN-1:0]  EX_PC;
    logic [XLEN-1:0]  EX_RS1_Data;
    logic [XLEN-1:0]  EX_RS2_Data;
    logic [XLEN-1:0]  EX_Imm;
    logic [4:0]       EX_Rs1;
    logic [4:0]       EX_Rs2;
    logic [4:0]       EX_Rd;
    logic [CNT_W-1:0] Bubble_Count;

    // ID stage side: drives the control word and datapath values.
    modport master (
        output flush, hold, ID_Valid, ID_Load_Instr, ID_RF_Enable, RAM_Enable, RAM_RW,
               RAM_SE, JALR_Instr, JAL_Instr, AUIPC_Instr, ID_ALU_op, ID_shift_imm,
               RAM_Size, Comb_OpFunct, ID_PC, ID_RS1_Data, ID_RS2_Data, ID_Imm,
               ID_Rs1, ID_Rs2, ID_Rd,
        input  EX_Valid, EX_Load_Instr, EX_RF_Enable, EX_RAM_Enable, EX_RAM_RW,
               EX_RAM_SE, EX_JALR_Instr, EX_JAL_Instr, EX_AUIPC_Instr, EX_ALU_op,
               EX_shift_imm, EX_RAM_Size, EX_Comb_OpFunct, EX_PC, EX_RS1_Data,
               EX_RS2_Data, EX_Imm, EX_Rs1, EX_Rs2, EX_Rd, Bubble_Count
    );

    // Pipeline register side.
    modport slave (
        input  flush, hold, ID_Valid, ID_Load_Instr, ID_RF_Enable, RAM_Enable, RAM_RW,
               RAM_SE, JALR_Instr, JAL_Instr, AUIPC_Instr, ID_ALU_op, ID_shift_imm,
               RAM_Size, Comb_OpFunct, ID_PC, ID_RS1_Data, ID_RS2_Data, ID_Imm,
               ID_Rs1, ID_Rs2, ID_Rd,
        output EX_Valid, EX_Load_Instr, EX_RF_Enable, EX_RAM_Enable, EX_RAM_RW,
               EX_RAM_SE, EX_JALR_Instr, EX_JAL_Instr, EX_AUIPC_Instr, EX_ALU_op,
               EX_shift_imm, EX_RAM_Size, EX_Comb_OpFunct, EX_PC, EX_RS1_Data,
               EX_RS2_Data, EX_Imm, EX_Rs1, EX_Rs2, EX_Rd, Bubble_Count
    );
endinterface

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register with stall, squash, bubble masking and a saturating bubble counter.
module id_ex_pipeline_register #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input logic                    clk,
    input logic                    reset,
    id_ex_pipeline_register_if.slave bus
);
    localparam int unsigned CTRL_W = 8 + 4 + 3 + 2 + 10;
    localparam int unsigned DATA_W = 4 * XLEN + 3 * 5;

    logic [CTRL_W-1:0] ctrl_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              bubble;
    logic              cnt_sat;

    assign ctrl_d = {bus.ID_Load_Instr, bus.ID_RF_Enable, bus.RAM_Enable, bus.RAM_RW,
                     bus.RAM_SE, bus.JALR_Instr, bus.JAL_Instr, bus.AUIPC_Instr,
                     bus.ID_ALU_op, bus.ID_shift_imm, bus.RAM_Size, bus.Comb_OpFunct};
    assign data_d = {bus.ID_PC, bus.ID_RS1_Data, bus.ID_RS2_Data, bus.ID_Imm,
                     bus.ID_Rs1, bus.ID_Rs2, bus.ID_Rd};

    // A bubble enters EX on a squash, or on a load of an empty ID slot.
    always_comb begin
        bubble  = bus.flush | (~bus.hold & ~bus.ID_Valid);
        cnt_sat = &cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (bus.flush) begin
                ctrl_q  <= '0;
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (!bus.hold) begin
                // Control is forced to zero for bubbles so RF/RAM enables can never leak.
                ctrl_q  <= bus.ID_Valid ? ctrl_d : '0;
                data_q  <= data_d;
                valid_q <= bus.ID_Valid;
            end
            if (bubble && !cnt_sat) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign {bus.EX_Load_Instr, bus.EX_RF_Enable, bus.EX_RAM_Enable, bus.EX_RAM_RW,
            bus.EX_RAM_SE, bus.EX_JALR_Instr, bus.EX_JAL_Instr, bus.EX_AUIPC_Instr,
            bus.EX_ALU_op, bus.EX_shift_imm, bus.EX_RAM_Size, bus.EX_Comb_OpFunct} = ctrl_q;
    assign {bus.EX_PC, bus.EX_RS1_Data, bus.EX_RS2_Data, bus.EX_Imm,
            bus.EX_Rs1, bus.EX_Rs2, bus.EX_Rd} = data_q;
    assign bus.EX_Valid     = valid_q;
    assign bus.Bubble_Count = cnt_q;

endmodule

// File: doc/id_ex_pipeline_register.md
# id_ex_pipeline_register

ID/EX pipeline register of the RISC-V pipeline. It captures the ID-stage control word, after the hazard NOP-insertion multiplexer, together with the ID datapath values, and presents them to the EX stage one cycle later. It supports hold (stall) and flush (branch/jump squash). It also keeps a saturating count of bubbles entering EX, for performance debug.

## Interface
Parameters:
- XLEN, 32, datapath width for PC, operands and immediate.
- CNT_W, 32, width of the bubble counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset; one clock; sampled on the rising edge of clk.
- flush  in  1  squash: replace the EX contents with a bubble.
- hold  in  1  stall: keep the current EX contents.
- ID_Valid  in  1  ID slot holds a real instruction. It is 0 when the NOP mux selector is 1 or the slot was squashed.
- ID_Load_Instr, ID_RF_Enable, RAM_Enable, RAM_RW, RAM_SE, JALR_Instr, JAL_Instr, AUIPC_Instr  in  1 each  control bits from the control mux.
- ID_ALU_op  in  4  ALU operation.
- ID_shift_imm  in  3  shifter-operand select.
- RAM_Size  in  2  memory access size.
- Comb_OpFunct  in  10  combined opcode/funct tag.
- ID_PC  in  XLEN  instruction PC.
- ID_RS1_Data, ID_RS2_Data  in  XLEN each  register-file read data.
- ID_Imm  in  XLEN  sign-extended immediate.
- ID_Rs1, ID_Rs2, ID_Rd  in  5 each  register indices.
- EX_* outputs  out  same widths  one EX_-prefixed registered copy of every ID-side input above, including EX_Valid.
- Bubble_Count  out  CNT_W  number of bubbles that have entered EX.

## Operation
- Every output is a flop; there is no combinational path from input to output.
- The priority each rising edge is reset > flush > hold > load.
- reset: all EX_* outputs go to 0, EX_Valid goes to 0, and Bubble_Count goes to 0.
- flush: all EX_* control, data and index outputs go to 0 and EX_Valid goes to 0. The result is a canonical NOP: no RF write and no RAM access.
- hold (no flush): every EX_* output keeps its value and Bubble_Count is unchanged.
- load (no hold, no flush): every EX_* output takes its ID_* input.
- When a load captures ID_Valid=0, the control fields are expected to be zero already (forced by the mux). The register forces them to 0 anyway, so a bubble can never enable RF_Enable or RAM_Enable. Data fields are still captured.
- Bubble_Count increments by 1 on an edge with no reset where either of these holds:
  - flush=1;
  - load with ID_Valid=0.
- Bubble_Count saturates at all-ones and never wraps.
- Simultaneous flush and hold: flush wins and the counter increments.
- Reset while stalled: reset wins; all outputs are 0 on the next cycle.
- No state machine beyond the valid bit and the counter.

## Timing
- Latency is 1 cycle from ID_* inputs to EX_* outputs.
- Outputs change only on the rising edge of clk.
- All inputs are sampled on the same edge. The upstream mux output must be stable before that edge.
- hold and flush take effect on the edge at which they are sampled high. They are level-sensitive and must be held for every cycle they are meant to apply.
- Reset values: EX_* = 0 (all widths), EX_Valid = 0, Bubble_Count = 0.

## Test plan
- Reset: drive all inputs to non-zero values, with reset=1 for 1 cycle. Required: every EX_* output is 0, EX_Valid=0, Bubble_Count=0.
- Load: ID_Valid=1, ID_ALU_op=4'h5, ID_PC=32'h0000_0040, ID_Imm=32'hFFFF_FFFC, ID_Rd=5'd7, ID_RF_Enable=1.
  - Required, next cycle: EX_ALU_op=4'h5, EX_PC=32'h40, EX_Imm=32'hFFFF_FFFC, EX_Rd=7, EX_RF_Enable=1, EX_Valid=1, Bubble_Count unchanged.
- Hold: after a load of PC 0x40, set hold=1 for 3 cycles while ID_PC=0x44.
  - Required: EX_PC stays 0x40 for all 3 cycles and Bubble_Count does not change.
  - Release hold. Required: EX_PC=0x44 one cycle later.
- Flush priority: flush=1 and hold=1 together, with ID_Valid=1 and RAM_Enable=1. Required, next cycle: all EX_* = 0, EX_Valid=0, Bubble_Count incremented by 1.
- Bubble masking: ID_Valid=0 with RAM_Enable=1, RAM_RW=1, ID_RF_Enable=1. Required:
  - EX_RAM_Enable=0, EX_RAM_RW=0, EX_RF_Enable=0, EX_Valid=0;
  - data fields are captured;
  - Bubble_Count increments by 1.
- Saturation and reset-during-stall:
  - Preload Bubble_Count to 2^CNT_W-2 (CNT_W=4 build: 14) and apply 3 flushes. Required: the count reads 15, 15, 15.
  - Then apply reset with hold=1. Required: the count reads 0 and all outputs read 0.
